// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-bus controller between the MEM stage and the external
// data bus. Each MEM-stage request becomes one load or store. The bus
// handshake is ACKD with variable latency. Byte lanes are big-endian:
// offset 0 is DDT[31:24]. Loads are sign- or zero-extended.
// Misaligned accesses complete at once without a bus cycle. A bus cycle
// that sees no ACKD within TIMEOUT cycles is abandoned.
//
// Ports:
//   CLK1, RESET            clock (rising edge), async active-low reset
//   req, we, size, sext    MEM-stage access request and attributes
//   addr, wdata            byte address, right-justified store data
//   rdata                  extended load result
//   done                   one-cycle completion pulse
//   stall                  pipeline hold
//   err_align, err_timeout error flags, valid with done
//   DAD, DDT_OUT, DDT_IN   bus address, bus write data, bus read data
//   MREQ, WRITE, SIZE      bus request, write strobe, transfer size
//   ACKD                   bus acknowledge
//
// state | meaning
// IDLE  | waiting for req; checks alignment and launches the bus cycle
// BUS   | MREQ high, bus signals held, waiting for ACKD or timeout
// DONE  | one-cycle completion: done=1, stall released, flags valid
module dbus_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              CLK1,
  input  logic              RESET,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              err_align,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] DAD,
  output logic [31:0]       DDT_OUT,
  input  logic [31:0]       DDT_IN,
  output logic              MREQ,
  output logic              WRITE,
  output logic [1:0]        SIZE,
  input  logic              ACKD
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            ld_sext;
  logic            misalign;
  logic [31:0]     st_val;
  logic [31:0]     ld_val;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign stall      = req && (state != DONE);
  assign to_cnt_nxt = to_cnt + 1'b1;

  // Size 11 is reserved and behaves as a word.
  assign misalign = ((size == 2'b01) && addr[0]) ||
                    (size[1] && (addr[1:0] != 2'b00));

  always_comb begin
    st_val = wdata;
    case (size)
      2'b00:   st_val = {4{wdata[7:0]}};
      2'b01:   st_val = {2{wdata[15:0]}};
      default: st_val = wdata;
    endcase
  end

  // Lane selection uses the registered bus address and size, which stay
  // stable for the whole bus cycle.
  always_comb begin
    byte_v = DDT_IN[7:0];
    half_v = DDT_IN[15:0];
    ld_val = DDT_IN;
    case (DAD[1:0])
      2'd0:    byte_v = DDT_IN[31:24];
      2'd1:    byte_v = DDT_IN[23:16];
      2'd2:    byte_v = DDT_IN[15:8];
      default: byte_v = DDT_IN[7:0];
    endcase
    half_v = DAD[1] ? DDT_IN[15:0] : DDT_IN[31:16];
    case (SIZE)
      2'b00:   ld_val = {{24{ld_sext & byte_v[7]}}, byte_v};
      2'b01:   ld_val = {{16{ld_sext & half_v[15]}}, half_v};
      default: ld_val = DDT_IN;
    endcase
  end

  always_ff @(posedge CLK1 or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      MREQ        <= 1'b0;
      WRITE       <= 1'b0;
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      SIZE        <= 2'b00;
      DAD         <= '0;
      DDT_OUT     <= '0;
      rdata       <= '0;
      to_cnt      <= '0;
      ld_sext     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (misalign) begin
              done      <= 1'b1;
              err_align <= 1'b1;
              state     <= DONE;
            end else begin
              DAD     <= addr;
              SIZE    <= size;
              WRITE   <= we;
              MREQ    <= 1'b1;
              DDT_OUT <= we ? st_val : 32'h0;
              ld_sext <= sext;
              to_cnt  <= '0;
              state   <= BUS;
            end
          end
        end
        BUS: begin
          // ACKD is tested first so it wins over a timeout in the same cycle.
          if (ACKD) begin
            MREQ  <= 1'b0;
            WRITE <= 1'b0;
            done  <= 1'b1;
            if (!WRITE) rdata <= ld_val;
            state <= DONE;
          end else begin
            to_cnt <= to_cnt_nxt;
            if ((TIMEOUT != 0) && (to_cnt_nxt == TO_LIM)) begin
              MREQ        <= 1'b0;
              WRITE       <= 1'b0;
              done        <= 1'b1;
              err_timeout <= 1'b1;
              // A timed-out store keeps rdata, as every store does.
              if (!WRITE) rdata <= 32'h0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          done        <= 1'b0;
          err_align   <= 1'b0;
          err_timeout <= 1'b0;
          to_cnt      <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
module tb_dbus_ctrl;

  localparam int TOUT = 4;

  logic        CLK1 = 1'b0;
  logic        RESET = 1'b0;
  logic        req = 1'b0, we = 1'b0, sext = 1'b0, ACKD = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, DDT_IN = '0;
  logic [31:0] rdata, DAD, DDT_OUT;
  logic        done, stall, err_align, err_timeout, MREQ, WRITE;
  logic [1:0]  SIZE;

  int n_checks = 0;
  int n_fail   = 0;

  dbus_ctrl #(.ADDR_W(32), .TIMEOUT(TOUT), .TO_W(3)) dut (
    .CLK1(CLK1), .RESET(RESET), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .err_align(err_align), .err_timeout(err_timeout), .DAD(DAD),
    .DDT_OUT(DDT_OUT), .DDT_IN(DDT_IN), .MREQ(MREQ), .WRITE(WRITE),
    .SIZE(SIZE), .ACKD(ACKD)
  );

  always #5 CLK1 = ~CLK1;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ddt_in;
    int          ack_at;     // BUS cycle (1-based) carrying ACKD; 0 = never
    logic [31:0] exp_rdata;
    logic [31:0] exp_ddt;
    logic        exp_align;
    logic        exp_to;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string nm, logic w, logic [1:0] sz, logic sx,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] di,
                              int ack, logic [31:0] er, logic [31:0] ed,
                              logic ea, logic et);
    vec_t v;
    v.name = nm; v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd;
    v.ddt_in = di; v.ack_at = ack; v.exp_rdata = er; v.exp_ddt = ed;
    v.exp_align = ea; v.exp_to = et;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts on a negedge with the bus idle; ends on a negedge after done.
  task automatic run_vec(vec_t v);
    int cyc, bus, exp_cyc, exp_bus;
    bit seen;
    exp_bus = v.exp_align ? 0 : (v.ack_at != 0 ? v.ack_at : TOUT);
    exp_cyc = v.exp_align ? 1 : 1 + exp_bus;
    req = 1'b1; we = v.we; size = v.size; sext = v.sext; addr = v.addr;
    wdata = v.wdata; DDT_IN = v.ddt_in; ACKD = 1'b0;
    #1;
    chk({v.name, ".stall0"}, {31'b0, stall}, 32'h1);
    chk({v.name, ".mreq0"}, {31'b0, MREQ}, 32'h0);
    cyc = 0; bus = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge CLK1);
      cyc++;
      if (done) begin
        seen = 1;
        ACKD = 1'b0;
      end else if (MREQ) begin
        bus++;
        if (bus == 1) begin
          chk({v.name, ".dad"}, DAD, v.addr);
          chk({v.name, ".size"}, {30'b0, SIZE}, {30'b0, v.size});
          chk({v.name, ".write"}, {31'b0, WRITE}, {31'b0, v.we});
          chk({v.name, ".stall1"}, {31'b0, stall}, 32'h1);
          if (v.we) chk({v.name, ".ddt_out"}, DDT_OUT, v.exp_ddt);
        end
        ACKD = (v.ack_at == bus);
      end else begin
        ACKD = 1'b0;
      end
    end
    chk({v.name, ".done_seen"}, {31'b0, seen}, 32'h1);
    chk({v.name, ".done_cyc"}, cyc, exp_cyc);
    chk({v.name, ".bus_cycles"}, bus, exp_bus);
    chk({v.name, ".stall_done"}, {31'b0, stall}, 32'h0);
    chk({v.name, ".mreq_done"}, {31'b0, MREQ}, 32'h0);
    chk({v.name, ".rdata"}, rdata, v.exp_rdata);
    chk({v.name, ".err_align"}, {31'b0, err_align}, {31'b0, v.exp_align});
    chk({v.name, ".err_timeout"}, {31'b0, err_timeout}, {31'b0, v.exp_to});
    req = 1'b0;
    @(negedge CLK1);
    chk({v.name, ".done_pulse"}, {31'b0, done}, 32'h0);
    chk({v.name, ".flags_clr"}, {30'b0, err_align, err_timeout}, 32'h0);
  endtask

  initial begin
    vecs[0]  = mk("ld_word",    0, 2'b10, 0, 32'h100, 0, 32'h89ABCDEF, 1, 32'h89ABCDEF, 0, 0, 0);
    vecs[1]  = mk("ld_byte_sx", 0, 2'b00, 1, 32'h103, 0, 32'h000000F0, 4, 32'hFFFFFFF0, 0, 0, 0);
    vecs[2]  = mk("ld_byte_zx", 0, 2'b00, 0, 32'h103, 0, 32'h000000F0, 4, 32'h000000F0, 0, 0, 0);
    vecs[3]  = mk("ld_half_sx", 0, 2'b01, 1, 32'h102, 0, 32'h00008001, 1, 32'hFFFF8001, 0, 0, 0);
    vecs[4]  = mk("st_half",    1, 2'b01, 0, 32'h022, 32'h1234ABCD, 0, 2, 32'hFFFF8001, 32'hABCDABCD, 0, 0);
    vecs[5]  = mk("ld_misal",   0, 2'b10, 0, 32'h102, 0, 32'h5555AAAA, 1, 32'hFFFF8001, 0, 1, 0);
    vecs[6]  = mk("ld_tmo",     0, 2'b10, 0, 32'h200, 0, 32'h13572468, 0, 32'h00000000, 0, 0, 1);
    vecs[7]  = mk("ld_ack_lim", 0, 2'b10, 0, 32'h204, 0, 32'h11223344, 4, 32'h11223344, 0, 0, 0);
    vecs[8]  = mk("ld_byte0",   0, 2'b00, 1, 32'h100, 0, 32'h80FFFFFF, 2, 32'hFFFFFF80, 0, 0, 0);
    vecs[9]  = mk("st_byte",    1, 2'b00, 0, 32'h001, 32'hFFFFFF5A, 0, 1, 32'hFFFFFF80, 32'h5A5A5A5A, 0, 0);
    vecs[10] = mk("ld_half0",   0, 2'b01, 0, 32'h100, 0, 32'hBEEF0000, 3, 32'h0000BEEF, 0, 0, 0);
    vecs[11] = mk("ld_size11",  0, 2'b11, 1, 32'h300, 0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 0, 0);

    // Outputs under reset.
    #2;
    chk("rst.mreq", {31'b0, MREQ}, 32'h0);
    chk("rst.done", {31'b0, done}, 32'h0);
    chk("rst.dad", DAD, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.size", {30'b0, SIZE}, 32'h0);
    @(negedge CLK1); @(negedge CLK1);
    RESET = 1'b1;
    @(negedge CLK1);

    // ACKD with no access in flight must do nothing.
    ACKD = 1'b1;
    @(negedge CLK1);
    ACKD = 1'b0;
    #1;
    chk("stray_ack.done", {31'b0, done}, 32'h0);
    chk("stray_ack.stall", {31'b0, stall}, 32'h0);
    @(negedge CLK1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset in the middle of a store's bus cycle.
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h400; wdata = 32'hDEADBEEF;
    @(negedge CLK1);
    @(negedge CLK1);
    chk("midrst.mreq_before", {31'b0, MREQ}, 32'h1);
    RESET = 1'b0;
    #1;
    chk("midrst.mreq", {31'b0, MREQ}, 32'h0);
    chk("midrst.write", {31'b0, WRITE}, 32'h0);
    chk("midrst.dad", DAD, 32'h0);
    chk("midrst.ddt_out", DDT_OUT, 32'h0);
    chk("midrst.rdata", rdata, 32'h0);
    req = 1'b0;
    @(negedge CLK1);
    RESET = 1'b1;
    @(negedge CLK1);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
Parametrised data-bus controller between the MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD).
- Runs one load or store per request with a variable-latency ACKD handshake, big-endian byte-lane steering and sign/zero extension.
- Flags misaligned accesses and a configurable bus timeout.
- Drives a stall to the pipeline until each access completes.

Parameters:
ADDR_W, 32, address width for addr and DAD.
TIMEOUT, 255, max cycles in BUS waiting for ACKD; 0 disables the timeout.
TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
CLK1  in  1  clock, rising edge.
RESET  in  1  asynchronous reset, active-low.
req  in  1  MEM-stage access request; held high until done.
we  in  1  1 = store, 0 = load.
size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
sext  in  1  loads only: 1 sign-extend, 0 zero-extend.
addr  in  ADDR_W  byte address.
wdata  in  32  store data, right-justified.
rdata  out  32  load result, extended.
done  out  1  one-cycle completion pulse.
stall  out  1  hold the pipeline.
err_align  out  1  misaligned access; valid with done.
err_timeout  out  1  bus timeout; valid with done.
DAD  out  ADDR_W  bus address.
DDT_OUT  out  32  bus write data.
DDT_IN  in  32  bus read data.
MREQ  out  1  bus request.
WRITE  out  1  bus write strobe.
SIZE  out  2  bus size; same encoding as size.
ACKD  in  1  bus acknowledge.

Behaviour:
Reset values, applied immediately on RESET low, including mid-access:
- state = IDLE.
- MREQ, WRITE, done, err_align, err_timeout = 0.
- SIZE = 00; DAD, DDT_OUT, rdata = 0; timeout counter = 0.

States: IDLE, BUS, DONE.
- stall = req && (state != DONE). This is combinational, so it asserts in the same cycle req rises.
- IDLE, req=1, misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with err_align=1. No bus cycle; MREQ stays 0.
- IDLE, req=1, aligned: register DAD=addr, SIZE=size and WRITE=we, and set MREQ=1; go to BUS. MREQ is first high the cycle after req.
- Store lane replication: byte puts {4{wdata[7:0]}} on DDT_OUT; half puts {2{wdata[15:0]}}; word puts wdata.
- BUS: MREQ, DAD, SIZE, WRITE and DDT_OUT are held stable.
  - ACKD=1: drop MREQ/WRITE, go to DONE.
  - On a load, capture and extend the lane selected from DDT_IN.
  - Byte lanes: addr[1:0]=0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - Half lanes: addr[1]=0 selects [31:16], 1 selects [15:0].
- Timeout: the counter increments each BUS cycle with ACKD=0. If TIMEOUT!=0 and the count reaches TIMEOUT, drop MREQ and go to DONE with err_timeout=1; rdata = 0.
- ACKD on the same cycle the count reaches TIMEOUT counts as a normal ACK; ACK wins.
- ACKD outside BUS is ignored.
- DONE: lasts exactly one cycle with done=1 and stall=0, so the pipeline advances. rdata and the error flags are valid this cycle. Then return to IDLE and clear the error flags and counter.
- A req still high in IDLE after DONE is a new access.
- A store leaves rdata unchanged.
- Minimum latency with ACKD in the first BUS cycle: req at cycle 0, MREQ at cycle 1, done at cycle 2. Stall is high for cycles 0 and 1.
- req dropping while in BUS is not allowed; the access completes regardless.

Test Plan:
1. Reset then a word load at addr 0x100, DDT_IN=0x89ABCDEF, ACKD in the first BUS cycle -> MREQ high 1 cycle, DAD=0x100, SIZE=10; done at cycle 2 with rdata=0x89ABCDEF; stall high for 2 cycles.
2. Byte load, addr 0x103, sext=1, DDT_IN=0x000000F0, ACKD after 3 wait cycles -> rdata=0xFFFFFFF0. Repeat with sext=0 -> 0x000000F0. Half load at addr 0x102, sext=1, DDT_IN=0x00008001 -> rdata=0xFFFF8001.
3. Half store, wdata=0x1234ABCD, addr 0x22 -> WRITE=1, SIZE=01, DDT_OUT=0xABCDABCD during BUS; rdata unchanged.
4. Word load at addr 0x102 -> no MREQ; done and err_align=1 at cycle 1.
5. TIMEOUT=4 with ACKD never asserted -> MREQ drops after 4 BUS cycles; done and err_timeout=1, rdata=0. Rerun with ACKD arriving on cycle 4 -> normal completion, err_timeout=0.
6. RESET low mid-BUS -> MREQ, WRITE and stall-relevant state clear immediately. After release, a new access completes normally.
